// File: rtl/image_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : image_ram_arbiter
// Description : Shares one single-port image RAM between a burst block writer
//               and a reader, with a guaranteed reader slot before preemption.
// Revision    : 1.0 - initial release
// ============================================================================
module image_ram_arbiter #(
    parameter int PIXEL_WIDTH             = 8,
    parameter int IMAGE_RAM_ADDRESS_WIDTH = 17,
    parameter int WRITE_BURST             = 64,
    parameter int READ_SLOT               = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               wr_req,
    input  logic                               wr_en,
    input  logic [IMAGE_RAM_ADDRESS_WIDTH-1:0] wr_address,
    input  logic [PIXEL_WIDTH-1:0]             wr_data,
    output logic                               wr_grant,
    output logic                               wr_error,
    input  logic                               rd_req,
    input  logic                               rd_en,
    input  logic [IMAGE_RAM_ADDRESS_WIDTH-1:0] rd_address,
    output logic                               rd_grant,
    output logic [PIXEL_WIDTH-1:0]             rd_data,
    output logic                               rd_valid,
    output logic [IMAGE_RAM_ADDRESS_WIDTH-1:0] image_RAM_address,
    output logic [PIXEL_WIDTH-1:0]             image_RAM_data,
    output logic                               image_RAM_CE,
    output logic                               image_RAM_WE,
    input  logic [PIXEL_WIDTH-1:0]             image_RAM_q
);

    localparam int c_BEAT_W = $clog2(WRITE_BURST) + 1;
    localparam int c_SLOT_W = $clog2(READ_SLOT) + 1;
    localparam logic [c_BEAT_W-1:0] c_BURST_LAST = c_BEAT_W'(WRITE_BURST - 1);
    localparam logic [c_SLOT_W-1:0] c_SLOT_MAX   = c_SLOT_W'(READ_SLOT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [c_BEAT_W-1:0]     r_beat_cnt;
    logic [c_SLOT_W-1:0]     r_slot_cnt;
    logic                    r_read_owed;
    logic                    r_wr_error;
    logic                    r_rd_valid;
    logic [PIXEL_WIDTH-1:0]  r_rd_data;
    logic                    w_last_beat;
    logic                    w_in_write;
    logic                    w_in_read;

    assign w_last_beat = (r_state == WRITE) && wr_en && (r_beat_cnt == c_BURST_LAST);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (r_read_owed && rd_req) w_next_state = READ;
                else if (wr_req)           w_next_state = WRITE;
                else if (rd_req)           w_next_state = READ;
            end
            WRITE: begin
                if (w_last_beat) w_next_state = IDLE;
            end
            READ: begin
                if (!rd_req || ((r_slot_cnt == c_SLOT_MAX) && wr_req)) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_beat_cnt  <= '0;
            r_slot_cnt  <= '0;
            r_read_owed <= 1'b0;
            r_wr_error  <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
        end else begin
            r_state <= w_next_state;

            if (r_state != WRITE || w_last_beat) r_beat_cnt <= '0;
            else if (wr_en)                      r_beat_cnt <= r_beat_cnt + 1'b1;

            if (r_state != READ || w_next_state != READ) r_slot_cnt <= '0;
            else if (r_slot_cnt != c_SLOT_MAX)           r_slot_cnt <= r_slot_cnt + 1'b1;

            // Reader that waited through a whole burst wins the next IDLE decision
            if (w_last_beat && rd_req)                          r_read_owed <= 1'b1;
            else if (r_state == IDLE && w_next_state == READ)   r_read_owed <= 1'b0;

            if (wr_en && r_state != WRITE) r_wr_error <= 1'b1;

            r_rd_valid <= (r_state == READ) && rd_en;
            if (r_rd_valid) r_rd_data <= image_RAM_q;
        end
    end

    // Reset masks everything immediately rather than waiting for the next edge
    assign w_in_write = (r_state == WRITE) && !rst;
    assign w_in_read  = (r_state == READ)  && !rst;
    assign wr_grant   = w_in_write;
    assign rd_grant   = w_in_read;
    assign wr_error   = r_wr_error && !rst;
    assign rd_valid   = r_rd_valid && !rst;
    assign rd_data    = rst ? '0 : (r_rd_valid ? image_RAM_q : r_rd_data);

    always_comb begin
        image_RAM_address = '0;
        image_RAM_data    = '0;
        image_RAM_CE      = 1'b0;
        image_RAM_WE      = 1'b0;
        if (w_in_write) begin
            image_RAM_address = wr_address;
            image_RAM_data    = wr_data;
            image_RAM_CE      = wr_en;
            image_RAM_WE      = wr_en;
        end else if (w_in_read) begin
            image_RAM_address = rd_address;
            image_RAM_CE      = rd_en;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_image_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_image_ram_arbiter
// Description : Directed self-checking bench for image_ram_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_image_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_req, wr_en, rd_req, rd_en;
    logic [16:0] wr_address, rd_address;
    logic [7:0]  wr_data;
    logic        wr_grant, wr_error, rd_grant, rd_valid;
    logic [7:0]  rd_data;
    logic [16:0] image_RAM_address;
    logic [7:0]  image_RAM_data;
    logic        image_RAM_CE, image_RAM_WE;
    logic [7:0]  image_RAM_q;

    int checks = 0;
    int errors = 0;
    int ram_writes = 0;
    logic [16:0] last_waddr;
    logic [7:0]  last_wdata;

    always #5 clk = ~clk;

    image_ram_arbiter dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_en(wr_en), .wr_address(wr_address), .wr_data(wr_data),
        .wr_grant(wr_grant), .wr_error(wr_error),
        .rd_req(rd_req), .rd_en(rd_en), .rd_address(rd_address),
        .rd_grant(rd_grant), .rd_data(rd_data), .rd_valid(rd_valid),
        .image_RAM_address(image_RAM_address), .image_RAM_data(image_RAM_data),
        .image_RAM_CE(image_RAM_CE), .image_RAM_WE(image_RAM_WE),
        .image_RAM_q(image_RAM_q)
    );

    function automatic logic [7:0] ram_val(input logic [16:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    // RAM model: 1-cycle read latency, content derived from the address
    always @(posedge clk) begin
        if (image_RAM_CE && !image_RAM_WE) image_RAM_q <= ram_val(image_RAM_address);
        if (image_RAM_CE && image_RAM_WE) begin
            ram_writes <= ram_writes + 1;
            last_waddr <= image_RAM_address;
            last_wdata <= image_RAM_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue n writer beats starting at block index first; pixel i of block at row*320+col
    task automatic beats(input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            wr_en      = 1'b1;
            wr_address = 17'((i / 8) * 320 + (i % 8));
            wr_data    = 8'(i);
            #1;
            check("beat_we", {image_RAM_CE, image_RAM_WE}, 2'b11);
            check("beat_addr", image_RAM_address, 17'((i / 8) * 320 + (i % 8)));
            tick();
        end
        wr_en = 1'b0;
    endtask

    int base;
    int nread;

    initial begin
        rst = 1'b1; wr_req = 1'b0; wr_en = 1'b0; rd_req = 1'b0; rd_en = 1'b0;
        wr_address = '0; rd_address = '0; wr_data = '0;
        tick(); tick();
        #1;
        check("rst_grants", {wr_grant, rd_grant}, 2'b00);
        check("rst_flags", {rd_valid, wr_error, image_RAM_CE, image_RAM_WE}, 4'b0000);
        check("rst_rd_data", rd_data, 8'h00);

        // Single writer burst
        rst = 1'b0; wr_req = 1'b1;
        #1;
        check("idle_no_grant", wr_grant, 1'b0);
        tick();
        check("wr_granted", {wr_grant, rd_grant}, 2'b10);
        wr_req = 1'b0;
        base = ram_writes;
        beats(0, 63);
        check("wr_hold_63", wr_grant, 1'b1);
        beats(63, 1);
        check("wr_done_idle", wr_grant, 1'b0);
        check("wr_count", ram_writes - base, 64);
        check("wr_last_addr", last_waddr, 17'd2247);
        check("wr_last_data", last_wdata, 8'd63);

        // Reader alone: three reads then a read on the exit cycle
        rd_req = 1'b1;
        tick();
        check("rd_granted", {wr_grant, rd_grant}, 2'b01);
        check("rd_valid_idle", rd_valid, 1'b0);
        rd_en = 1'b1; rd_address = 17'd5;
        #1;
        check("rd_strobe", {image_RAM_CE, image_RAM_WE}, 2'b10);
        check("rd_addr", image_RAM_address, 17'd5);
        tick(); rd_address = 17'd6; #1;
        check("rd_v5", {rd_valid, rd_data}, {1'b1, ram_val(17'd5)});
        tick(); rd_address = 17'd7; #1;
        check("rd_v6", {rd_valid, rd_data}, {1'b1, ram_val(17'd6)});
        tick(); rd_en = 1'b0; #1;
        check("rd_v7", {rd_valid, rd_data}, {1'b1, ram_val(17'd7)});
        tick();
        check("rd_hold", {rd_valid, rd_data}, {1'b0, ram_val(17'd7)});
        rd_en = 1'b1; rd_address = 17'd9; rd_req = 1'b0;
        tick(); rd_en = 1'b0; #1;
        check("rd_last_cycle", {rd_grant, rd_valid, rd_data}, {2'b01, ram_val(17'd9)});

        // Stray strobes in IDLE
        wr_en = 1'b1; rd_en = 1'b1; wr_address = 17'd3; rd_address = 17'd4;
        #1;
        check("stray_no_strobe", {image_RAM_CE, image_RAM_WE}, 2'b00);
        tick(); wr_en = 1'b0; rd_en = 1'b0; #1;
        check("wr_error_set", wr_error, 1'b1);
        tick(); tick();
        check("wr_error_sticky", wr_error, 1'b1);
        rst = 1'b1; #1;
        check("wr_error_rst", wr_error, 1'b0);
        tick(); rst = 1'b0; #1;
        check("wr_error_clear", wr_error, 1'b0);

        // Simultaneous requests: writer first, then owed reader slot
        wr_req = 1'b1; rd_req = 1'b1;
        tick();
        check("both_wr_first", {wr_grant, rd_grant}, 2'b10);
        beats(0, 64);
        check("owed_idle", {wr_grant, rd_grant}, 2'b00);
        tick();
        check("owed_read", {wr_grant, rd_grant}, 2'b01);
        nread = 1;
        for (int k = 0; k < 40 && rd_grant; k++) begin
            tick();
            if (rd_grant) nread++;
        end
        check("read_slot_len", nread, 17);
        check("post_slot_idle", wr_grant, 1'b0);
        tick();
        check("wr_after_slot", {wr_grant, rd_grant}, 2'b10);
        rd_req = 1'b0;

        // Reset in the middle of a burst, then a full fresh burst
        beats(0, 29);
        wr_en = 1'b1; rst = 1'b1; #1;
        check("rst_mid_out", {wr_grant, image_RAM_CE, image_RAM_WE}, 3'b000);
        tick(); rst = 1'b0; wr_en = 1'b0; #1;
        check("rst_mid_idle", {wr_grant, rd_grant}, 2'b00);
        tick();
        check("rst_new_grant", wr_grant, 1'b1);
        wr_req = 1'b0;
        base = ram_writes;
        beats(0, 63);
        check("rst_new_hold", wr_grant, 1'b1);
        beats(63, 1);
        check("rst_new_done", wr_grant, 1'b0);
        check("rst_new_count", ram_writes - base, 64);
        check("no_wr_error", wr_error, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/image_ram_arbiter.md
IMAGE_RAM_ARBITER -- requirements
Module: image_ram_arbiter

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 8, pixel data width.
REQ-002 SHALL have parameter IMAGE_RAM_ADDRESS_WIDTH, default 17, image RAM address width.
REQ-003 SHALL have parameter WRITE_BURST, default 64, writer beats per grant (one 8x8 block).
REQ-004 SHALL have parameter READ_SLOT, default 16, guaranteed reader cycles before a pending writer may preempt.
REQ-005 SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port wr_req  input  1  block writer requests a burst.
REQ-008 SHALL have port wr_en  input  1  writer beat valid.
REQ-009 SHALL have port wr_address  input  IMAGE_RAM_ADDRESS_WIDTH  writer pixel address.
REQ-010 SHALL have port wr_data  input  PIXEL_WIDTH  writer pixel.
REQ-011 SHALL have port wr_grant  output  1  writer owns RAM.
REQ-012 SHALL have port wr_error  output  1  sticky: wr_en seen while wr_grant=0.
REQ-013 SHALL have port rd_req  input  1  reader (display/readback) requests access.
REQ-014 SHALL have port rd_en  input  1  read beat valid.
REQ-015 SHALL have port rd_address  input  IMAGE_RAM_ADDRESS_WIDTH  read address.
REQ-016 SHALL have port rd_grant  output  1  reader owns RAM.
REQ-017 SHALL have port rd_data  output  PIXEL_WIDTH  registered read data.
REQ-018 SHALL have port rd_valid  output  1  rd_data valid this cycle.
REQ-019 SHALL have ports image_RAM_address (output, IMAGE_RAM_ADDRESS_WIDTH), image_RAM_data (output, PIXEL_WIDTH), image_RAM_CE (output, 1), image_RAM_WE (output, 1) and image_RAM_q (input, PIXEL_WIDTH): single-port RAM with 1-cycle read latency.

Function
REQ-020 SHALL implement FSM states IDLE, WRITE, READ; wr_grant=1 exactly in WRITE, rd_grant=1 exactly in READ.
REQ-021 IDLE: read_owed=1 and rd_req=1 -> READ; else wr_req=1 -> WRITE; else rd_req=1 -> READ; else stay.
REQ-022 WRITE: beat counter increments on each wr_en=1 cycle; on the WRITE_BURST-th beat, FSM -> IDLE next cycle and counter clears.
REQ-023 WRITE exit SHALL set read_owed if rd_req=1 on that cycle; entering READ clears read_owed.
REQ-024 WRITE SHALL ignore wr_req/rd_req changes; no preemption mid-burst.
REQ-025 READ: slot counter increments every cycle, saturating at READ_SLOT.
REQ-026 READ -> IDLE when rd_req=0, or when slot counter = READ_SLOT and wr_req=1; else stay; slot counter clears on exit.
REQ-027 Outputs to RAM SHALL be combinational from state: WRITE -> address/data from writer, CE=WE=wr_en; READ -> address=rd_address, CE=rd_en, WE=0, data=0; IDLE -> all zero.
REQ-028 rd_valid SHALL be 1 the cycle after a READ cycle with rd_en=1, and rd_data SHALL then hold image_RAM_q; otherwise rd_valid=0 and rd_data holds its last value.
REQ-029 A read issued on the last READ cycle SHALL still return rd_valid the following cycle.
REQ-030 wr_en while not in WRITE, and rd_en while not in READ, SHALL not reach the RAM; the former sets wr_error until reset.
REQ-031 Beat counter width SHALL be $clog2(WRITE_BURST)+1, slot counter $clog2(READ_SLOT)+1; no wrap.

Reset
REQ-032 rst=1 SHALL force IDLE, clear counters and read_owed, set wr_grant=rd_grant=rd_valid=wr_error=0, rd_data=0, and RAM strobes 0 in the same cycle, including mid-burst.
REQ-033 First grant after reset release SHALL be decided on the first cycle with rst=0.

Verification
REQ-034 wr_req=1 only, 64 wr_en beats at addresses 0..7,320..327,... -> wr_grant 64+ cycles, 64 RAM writes with WE=1, IDLE after beat 64.
REQ-035 rd_req=1 only, rd_en at addresses 5,6,7 -> CE=1/WE=0, rd_valid on cycles +1..+3 with matching image_RAM_q.
REQ-036 rd_req held during full write burst, wr_req re-asserted immediately -> READ granted next, writer waits >=16 cycles before WRITE.
REQ-037 wr_en pulsed in IDLE -> no RAM strobe, wr_error=1 until rst.
REQ-038 rst asserted at write beat 30 -> IDLE next edge, outputs zero; new burst counts 64 beats from zero.
REQ-039 wr_req and rd_req rising together from IDLE, read_owed=0 -> WRITE granted first.
